// File: rtl/store_drain_unit_pkg.sv
// Shared definitions for the store drain path: store data buffer entry layout
// and drain FSM encoding.
package store_drain_unit_pkg;

  // Entry layout of the store data buffer: {data, addr}
  localparam int SDB_ADDR_LSB = 0;
  localparam int SDB_ADDR_W   = 16;
  localparam int SDB_DATA_LSB = 16;
  localparam int SDB_DATA_W   = 16;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } drain_state_e;

  function automatic logic [1:0] popcnt2(input logic [1:0] v);
    return {v[1] & v[0], v[1] ^ v[0]};
  endfunction

endpackage

// File: rtl/store_drain_unit_commit_fifo.sv
// Two-in/one-out index FIFO holding retired stores in program order.
// A commit that does not fit is dropped whole and latches a sticky overflow.
module commit_fifo
  import store_drain_unit_pkg::*;
#(
  parameter int IDX_WIDTH = 3,
  parameter int QDEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               push_valid_i,
  input  logic [IDX_WIDTH-1:0]     push_idx0_i,
  input  logic [IDX_WIDTH-1:0]     push_idx1_i,
  input  logic                     pop_i,
  output logic [IDX_WIDTH-1:0]     head_o,
  output logic [$clog2(QDEPTH):0]  count_o,
  output logic                     ready_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(QDEPTH);
  localparam int PW = AW + 1;

  logic [IDX_WIDTH-1:0] mem_q [QDEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        count, wr_p1;
  logic [PW:0]          fill;
  logic [1:0]           need;
  logic                 fits, push, do_pop;
  logic                 ovf_q, ovf_d;

  // Wrap bit makes the pointer difference span 0..QDEPTH
  assign count = wr_ptr_q - rd_ptr_q;

  always_comb begin
    need     = popcnt2(push_valid_i);
    fill     = (PW+1)'(count) + (PW+1)'(need);
    fits     = (fill <= (PW+1)'(QDEPTH));
    push     = (need != 2'd0) && fits;
    do_pop   = pop_i && (count != '0);
    wr_p1    = wr_ptr_q + PW'(1);
    wr_ptr_d = push ? (wr_ptr_q + PW'(need)) : wr_ptr_q;
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    ovf_d    = ovf_q | ((need != 2'd0) && !fits);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      // A lone slot-1 commit is packed at the write pointer, no hole
      if (push) begin
        if (push_valid_i[0]) begin
          mem_q[wr_ptr_q[AW-1:0]] <= push_idx0_i;
          if (push_valid_i[1]) mem_q[wr_p1[AW-1:0]] <= push_idx1_i;
        end else begin
          mem_q[wr_ptr_q[AW-1:0]] <= push_idx1_i;
        end
      end
    end
  end

  assign head_o     = mem_q[rd_ptr_q[AW-1:0]];
  assign count_o    = count;
  assign ready_o    = (count <= PW'(QDEPTH - 2));
  assign overflow_o = ovf_q;

endmodule

// File: rtl/store_drain_unit.sv
// Drains retired stores: reads each queued store buffer entry, writes it to
// data memory under req/ack, then releases the entry back to the free pool.
module store_drain_unit
  import store_drain_unit_pkg::*;
#(
  parameter int DATA_WIDTH = SDB_DATA_W,
  parameter int ADDR_WIDTH = SDB_ADDR_W,
  parameter int IDX_WIDTH  = 3,
  parameter int QDEPTH     = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [1:0]                      commit_valid,
  input  logic [IDX_WIDTH-1:0]            commit_idx0,
  input  logic [IDX_WIDTH-1:0]            commit_idx1,
  output logic                            commit_ready,
  output logic [IDX_WIDTH-1:0]            sdb_rd_idx,
  input  logic [DATA_WIDTH+ADDR_WIDTH-1:0] sdb_rd_data,
  output logic                            mem_wr_req,
  output logic [ADDR_WIDTH-1:0]           mem_wr_addr,
  output logic [DATA_WIDTH-1:0]           mem_wr_data,
  input  logic                            mem_wr_ack,
  output logic                            sdb_free_valid,
  output logic [IDX_WIDTH-1:0]            sdb_free_idx,
  output logic                            drain_empty,
  output logic                            err_overflow
);

  localparam int CW = $clog2(QDEPTH) + 1;

  drain_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic                  free_vld_q, free_vld_d;
  logic [IDX_WIDTH-1:0]  free_idx_q, free_idx_d;
  logic [IDX_WIDTH-1:0]  head;
  logic [CW-1:0]         count;
  logic                  pop;

  commit_fifo #(
    .IDX_WIDTH (IDX_WIDTH),
    .QDEPTH    (QDEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_valid_i (commit_valid),
    .push_idx0_i  (commit_idx0),
    .push_idx1_i  (commit_idx1),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (count),
    .ready_o      (commit_ready),
    .overflow_o   (err_overflow)
  );

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    idx_d      = idx_q;
    free_vld_d = 1'b0;
    free_idx_d = free_idx_q;
    case (state_q)
      S_IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // Ack retires the current store; chain straight into the next one
        if (mem_wr_ack) begin
          free_vld_d = 1'b1;
          free_idx_d = idx_q;
          if (count != '0) pop = 1'b1;
          else             state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      addr_d = sdb_rd_data[SDB_ADDR_LSB +: ADDR_WIDTH];
      data_d = sdb_rd_data[SDB_DATA_LSB +: DATA_WIDTH];
      idx_d  = head;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      free_vld_q <= 1'b0;
      free_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      free_vld_q <= free_vld_d;
      free_idx_q <= free_idx_d;
    end
  end

  assign sdb_rd_idx     = head;
  assign mem_wr_req     = (state_q == S_WRITE);
  assign mem_wr_addr    = addr_q;
  assign mem_wr_data    = data_q;
  assign sdb_free_valid = free_vld_q;
  assign sdb_free_idx   = free_idx_q;
  assign drain_empty    = (state_q == S_IDLE) && (count == '0);

endmodule

// File: tb/tb_store_drain_unit.sv
// Scoreboard bench for store_drain_unit: committed indices queue their
// expected memory writes, which are popped as req/ack handshakes complete.
module tb_store_drain_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  commit_valid = 2'b00;
  logic [2:0]  commit_idx0 = 3'd0;
  logic [2:0]  commit_idx1 = 3'd0;
  logic        commit_ready;
  logic [2:0]  sdb_rd_idx;
  logic [31:0] sdb_rd_data;
  logic        mem_wr_req;
  logic [15:0] mem_wr_addr;
  logic [15:0] mem_wr_data;
  logic        mem_wr_ack = 1'b0;
  logic        sdb_free_valid;
  logic [2:0]  sdb_free_idx;
  logic        drain_empty;
  logic        err_overflow;

  logic [15:0] sdb_addr [8];
  logic [15:0] sdb_data [8];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cyc = 0;
  int prev_wr_cyc = 0;
  logic [2:0] exp_q [$];
  bit         free_due = 1'b0;
  logic [2:0] free_exp = 3'd0;

  always #5 clk = ~clk;

  assign sdb_rd_data = {sdb_data[sdb_rd_idx], sdb_addr[sdb_rd_idx]};

  store_drain_unit dut (
    .clk            (clk),
    .rst            (rst),
    .commit_valid   (commit_valid),
    .commit_idx0    (commit_idx0),
    .commit_idx1    (commit_idx1),
    .commit_ready   (commit_ready),
    .sdb_rd_idx     (sdb_rd_idx),
    .sdb_rd_data    (sdb_rd_data),
    .mem_wr_req     (mem_wr_req),
    .mem_wr_addr    (mem_wr_addr),
    .mem_wr_data    (mem_wr_data),
    .mem_wr_ack     (mem_wr_ack),
    .sdb_free_valid (sdb_free_valid),
    .sdb_free_idx   (sdb_free_idx),
    .drain_empty    (drain_empty),
    .err_overflow   (err_overflow)
  );

  // Scores the handshake about to be sampled, then advances one clock.
  task automatic step();
    logic [2:0] e;
    checks++;
    if (free_due) begin
      if (sdb_free_valid !== 1'b1 || sdb_free_idx !== free_exp) begin
        errors++;
        $display("FAIL free_pulse got valid=%b idx=%0d want valid=1 idx=%0d",
                 sdb_free_valid, sdb_free_idx, free_exp);
      end
      free_due = 1'b0;
    end else if (sdb_free_valid !== 1'b0) begin
      errors++;
      $display("FAIL free_spurious got valid=%b idx=%0d want valid=0",
               sdb_free_valid, sdb_free_idx);
    end
    if (mem_wr_req === 1'b1 && mem_wr_ack === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected got addr=%h data=%h want no write",
                 mem_wr_addr, mem_wr_data);
      end else begin
        e = exp_q.pop_front();
        if (mem_wr_addr !== sdb_addr[e] || mem_wr_data !== sdb_data[e]) begin
          errors++;
          $display("FAIL write_order got addr=%h data=%h want addr=%h data=%h (idx %0d)",
                   mem_wr_addr, mem_wr_data, sdb_addr[e], sdb_data[e], e);
        end
        free_due    = 1'b1;
        free_exp    = e;
        prev_wr_cyc = wr_cyc;
        wr_cyc      = cyc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_commit(input logic [1:0] v, input logic [2:0] i0, input logic [2:0] i1,
                           input bit drop);
    commit_valid = v;
    commit_idx0  = i0;
    commit_idx1  = i1;
    if (!drop) begin
      if (v[0]) exp_q.push_back(i0);
      if (v[1]) exp_q.push_back(i1);
    end
    step();
    commit_valid = 2'b00;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((exp_q.size() != 0 || free_due || drain_empty !== 1'b1) && n < maxc) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || free_due || drain_empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_timeout got pending=%0d drain_empty=%b want pending=0 drain_empty=1",
               exp_q.size(), drain_empty);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (mem_wr_req !== 1'b0 || mem_wr_addr !== 16'h0 || mem_wr_data !== 16'h0 ||
        sdb_free_valid !== 1'b0 || sdb_free_idx !== 3'd0 || err_overflow !== 1'b0 ||
        commit_ready !== 1'b1 || drain_empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_values got req=%b addr=%h data=%h fv=%b fi=%0d ovf=%b rdy=%b empty=%b want 0 0 0 0 0 0 1 1",
               mem_wr_req, mem_wr_addr, mem_wr_data, sdb_free_valid, sdb_free_idx,
               err_overflow, commit_ready, drain_empty);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    mem_wr_ack = 1'b1;
    do_commit(2'b01, 3'd3, 3'd0, 1'b0);
    checks++;
    if (mem_wr_req !== 1'b0 || drain_empty !== 1'b0) begin
      errors++;
      $display("FAIL single_queued got req=%b empty=%b want req=0 empty=0", mem_wr_req, drain_empty);
    end
    step();
    checks++;
    if (mem_wr_req !== 1'b1 || mem_wr_addr !== 16'h0010 || mem_wr_data !== 16'h00AA) begin
      errors++;
      $display("FAIL single_req got req=%b addr=%h data=%h want req=1 addr=0010 data=00aa",
               mem_wr_req, mem_wr_addr, mem_wr_data);
    end
    drain(10);
  endtask

  task automatic test_dual();
    mem_wr_ack = 1'b1;
    do_commit(2'b11, 3'd1, 3'd5, 1'b0);
    drain(10);
    checks++;
    if (wr_cyc - prev_wr_cyc != 1) begin
      errors++;
      $display("FAIL dual_back_to_back got gap=%0d want gap=1", wr_cyc - prev_wr_cyc);
    end
  endtask

  task automatic test_wait_states();
    mem_wr_ack = 1'b0;
    do_commit(2'b01, 3'd2, 3'd0, 1'b0);
    step();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) mem_wr_ack = 1'b1;
      checks++;
      if (mem_wr_req !== 1'b1 || mem_wr_addr !== sdb_addr[2] || mem_wr_data !== sdb_data[2]) begin
        errors++;
        $display("FAIL wait_stable cycle %0d got req=%b addr=%h data=%h want req=1 addr=%h data=%h",
                 k, mem_wr_req, mem_wr_addr, mem_wr_data, sdb_addr[2], sdb_data[2]);
      end
      step();
    end
    mem_wr_ack = 1'b0;
    step();
    step();
    checks++;
    if (drain_empty !== 1'b1 || mem_wr_req !== 1'b0) begin
      errors++;
      $display("FAIL wait_done got empty=%b req=%b want empty=1 req=0", drain_empty, mem_wr_req);
    end
  endtask

  task automatic test_backpressure();
    mem_wr_ack = 1'b0;
    do_commit(2'b11, 3'd1, 3'd2, 1'b0);
    checks++;
    if (commit_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_two got ready=%b want 1", commit_ready);
    end
    do_commit(2'b11, 3'd3, 3'd4, 1'b0);
    checks++;
    if (commit_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_three got ready=%b want 0", commit_ready);
    end
    step();
    checks++;
    if (commit_ready !== 1'b0 || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold got ready=%b ovf=%b want ready=0 ovf=0", commit_ready, err_overflow);
    end
    mem_wr_ack = 1'b1;
    drain(20);
    checks++;
    if (commit_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got ready=%b want 1", commit_ready);
    end
  endtask

  task automatic test_overflow();
    mem_wr_ack = 1'b0;
    do_commit(2'b11, 3'd0, 3'd1, 1'b0);
    do_commit(2'b11, 3'd2, 3'd3, 1'b0);
    do_commit(2'b01, 3'd4, 3'd0, 1'b0);
    checks++;
    if (commit_ready !== 1'b0 || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full got ready=%b ovf=%b want ready=0 ovf=0", commit_ready, err_overflow);
    end
    do_commit(2'b01, 3'd6, 3'd0, 1'b1);
    step();
    step();
    checks++;
    if (err_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set got ovf=%b want 1", err_overflow);
    end
    mem_wr_ack = 1'b1;
    drain(20);
    checks++;
    if (err_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky got ovf=%b want 1", err_overflow);
    end
  endtask

  task automatic test_reset_mid_write();
    mem_wr_ack = 1'b0;
    do_commit(2'b11, 3'd5, 3'd6, 1'b0);
    do_commit(2'b01, 3'd7, 3'd0, 1'b0);
    checks++;
    if (mem_wr_req !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre got req=%b want 1", mem_wr_req);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (mem_wr_req !== 1'b0 || sdb_free_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async got req=%b fv=%b want req=0 fv=0", mem_wr_req, sdb_free_valid);
    end
    exp_q.delete();
    free_due = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    mem_wr_ack = 1'b1;
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (drain_empty !== 1'b1 || commit_ready !== 1'b1 || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after got empty=%b ready=%b ovf=%b want 1 1 0",
               drain_empty, commit_ready, err_overflow);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      sdb_addr[i] = 16'h0100 + 16'(i * 16);
      sdb_data[i] = 16'hD000 + 16'(i);
    end
    sdb_addr[3] = 16'h0010;
    sdb_data[3] = 16'h00AA;

    test_reset();
    test_single();
    test_dual();
    test_wait_states();
    test_backpressure();
    test_overflow();
    test_reset_mid_write();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
